data_mem_responder: RTL

- Responder (memory) end of the core's data-memory req/gnt/rvalid interface; it is the partner of the EX-stage initiator that the EX tracker observes.
- Used in simulation/FPGA builds as the core's data memory: grants requests after a configurable delay and returns responses after a configurable latency.
- Handles up to MAX_OUTSTANDING in-flight responses, so pipelined accesses and the tracker's WAIT_GNT timing paths can be exercised deterministically.

---
 rtl/data_mem_responder_pkg.sv | 31 +++
 rtl/mem_resp_fifo.sv | 76 +++++++
 rtl/data_mem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: response-queue entry, grant FSM states
// and the byte-enable merge used on writes.
package data_mem_responder_pkg;

  localparam int unsigned BeWidth   = 4;
  localparam int unsigned DataWidth = 32;
  // Wide enough for any practical RVALID_DELAY (up to 256).
  localparam int unsigned CdWidth   = 8;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [CdWidth-1:0]   countdown;
  } mem_resp_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StWaitGnt
  } gnt_state_e;

  function automatic logic [DataWidth-1:0] apply_be(input logic [DataWidth-1:0] old_word,
                                                    input logic [DataWidth-1:0] wdata,
                                                    input logic [BeWidth-1:0]   be);
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < BeWidth; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// In-order response queue with a per-entry countdown; the head is presented (registered)
// in the cycle its countdown has reached zero and is popped at the end of that cycle.
module mem_resp_fifo
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  mem_resp_entry_t      i_push_entry,
  input  logic                 i_pop,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CntW-1:0]      o_count,
  output logic                 o_head_ready,
  output logic [DataWidth-1:0] o_head_rdata
);

  mem_resp_entry_t      r_entries [Depth];
  logic [CntW-1:0]      r_count;
  logic                 r_head_ready;
  logic [DataWidth-1:0] r_rdata;

  mem_resp_entry_t      w_entries_d [Depth];
  logic [CntW-1:0]      w_count_d;
  logic                 w_head_ready_d;

  always_comb begin
    w_count_d = r_count;
    for (int i = 0; i < Depth; i++) begin
      w_entries_d[i] = r_entries[i];
      if (CntW'(i) < r_count && r_entries[i].countdown != '0) begin
        w_entries_d[i].countdown = r_entries[i].countdown - CdWidth'(1);
      end
    end
    if (i_pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        w_entries_d[i] = w_entries_d[i+1];
      end
      w_count_d = w_count_d - CntW'(1);
    end
    if (i_push) begin
      for (int i = 0; i < Depth; i++) begin
        if (CntW'(i) == w_count_d) w_entries_d[i] = i_push_entry;
      end
      w_count_d = w_count_d + CntW'(1);
    end
    // Looking at next-state lets rvalid be a register yet appear in the pop cycle itself.
    w_head_ready_d = (w_count_d != '0) && (w_entries_d[0].countdown == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_head_ready <= 1'b0;
      r_rdata      <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_count      <= w_count_d;
      r_entries    <= w_entries_d;
      r_head_ready <= w_head_ready_d;
      if (w_head_ready_d) r_rdata <= w_entries_d[0].rdata;
    end
  end

  assign o_full       = (r_count == CntW'(Depth));
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_head_ready = r_head_ready;
  assign o_head_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: grants after GNT_DELAY cycles of held req, performs the access at
// the grant edge, and returns responses in order RVALID_DELAY cycles later.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RVALID_DELAY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [BeWidth-1:0]    data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o
);

  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  localparam int unsigned WaitW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WaitW-1:0] GntDelayW = WaitW'(GNT_DELAY);

  gnt_state_e           r_state;
  logic [WaitW-1:0]     r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [IdxW-1:0]      w_idx;
  logic                 w_wait_done;
  logic                 w_can_accept;
  logic                 w_full;
  logic                 w_empty;
  logic [CntW-1:0]      w_count;
  logic                 w_pop;
  logic [DataWidth-1:0] w_rdata;
  mem_resp_entry_t      w_push_entry;
  logic                 w_unused;

  assign w_idx        = data_addr_i[IdxW+1:2];
  assign w_wait_done  = (r_wait_cnt == GntDelayW);
  assign w_can_accept = !w_full || w_pop;
  assign data_gnt_o   = !rst && data_req_i && w_wait_done && w_can_accept;

  // Upper address bits alias and the byte offset is ignored.
  assign w_unused = ^{data_addr_i[ADDR_WIDTH-1:IdxW+2], data_addr_i[1:0], w_empty, w_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (data_req_i && !data_gnt_o) begin
            r_state <= StWaitGnt;
            if (!w_wait_done) r_wait_cnt <= r_wait_cnt + WaitW'(1);
          end
        end
        StWaitGnt: begin
          if (!data_req_i || data_gnt_o) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
          end else if (!w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
          end
        end
        default: begin
          r_state    <= StIdle;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i) begin
      r_mem[w_idx] <= apply_be(r_mem[w_idx], data_wdata_i, data_be_i);
    end
  end

  always_comb begin
    w_push_entry.rdata     = data_we_i ? '0 : r_mem[w_idx];
    w_push_entry.countdown = CdWidth'(RVALID_DELAY - 1);
  end

  mem_resp_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (data_gnt_o),
    .i_push_entry(w_push_entry),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_ready(w_pop),
    .o_head_rdata(w_rdata)
  );

  assign data_rvalid_o = w_pop;
  assign data_rdata_o  = w_rdata;

endmodule
